// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter, one adjust-and-shift step per clock.
// Optional signed (sign-magnitude) input handling is enabled by defining BCD_SIGN_MAG_EN.
module bcd_converter_seq #(
    parameter int W_IN   = 17,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W_IN-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg
);

    localparam int ACC_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(W_IN + 1);
    localparam int PAIR_W = ACC_W + W_IN;

    // Handshake: start is a single-cycle request honoured only in IDLE; busy
    // is high from the accepting edge until the result edge; done pulses for
    // exactly one cycle while bcd_out/neg carry the fresh result.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t              state, state_next;
    logic [W_IN-1:0]     sr, sr_next;
    logic [ACC_W-1:0]    acc, acc_next, acc_adj;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [ACC_W-1:0]    bcd_q, bcd_next;
    logic [PAIR_W-1:0]   pair_shift;
    logic [W_IN-1:0]     magnitude;

`ifdef BCD_SIGN_MAG_EN
    logic in_sign;
    logic sign_pend;
    logic neg_q;

    // -bin_in stays within W_IN bits: the most-negative input maps to 2^(W_IN-1).
    always_comb begin
        in_sign   = bin_in[W_IN-1];
        magnitude = in_sign ? (-bin_in) : bin_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_pend <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            if (state == IDLE && start)
                sign_pend <= in_sign;
            if (state == SHIFT && cnt == CNT_W'(1))
                neg_q <= sign_pend;
        end
    end

    assign neg = neg_q;
`else
    assign magnitude = bin_in;
    assign neg       = 1'b0;
`endif

    // Per-digit +3 correction; no carry crosses digit boundaries.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    assign pair_shift = {acc_adj, sr} << 1;

    always_comb begin
        state_next = state;
        sr_next    = sr;
        acc_next   = acc;
        cnt_next   = cnt;
        bcd_next   = bcd_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    sr_next    = magnitude;
                    acc_next   = '0;
                    cnt_next   = CNT_W'(W_IN);
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                acc_next = pair_shift[PAIR_W-1:W_IN];
                sr_next  = pair_shift[W_IN-1:0];
                cnt_next = cnt - CNT_W'(1);
                // Last iteration: publish straight from the shifter so the
                // result lands on the same edge busy drops.
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                    bcd_next   = pair_shift[PAIR_W-1:W_IN];
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            bcd_q <= bcd_next;
        end
    end

    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Self-checking bench for bcd_converter_seq: drivers push expected results,
// a negedge monitor pops and compares them when done pulses.
module tb_bcd_converter_seq;

    localparam int W_IN   = 17;
    localparam int DIGITS = 6;
    localparam int LAT    = W_IN + 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [W_IN-1:0]      bin_in;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;
    logic                 neg;

    logic [4*DIGITS:0]    exp_q[$];
    int                   lat_q[$];
    logic [4*DIGITS-1:0]  last_exp;
    logic                 prev_done;
    int                   ncyc;
    int                   n_checks;
    int                   n_errors;

    bcd_converter_seq #(.W_IN(W_IN), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .neg     (neg)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // reference model: decimal digits by division, sign-magnitude if enabled
    function automatic logic [4*DIGITS:0] model(input logic [W_IN-1:0] v);
        int unsigned         m;
        logic                n;
        logic [4*DIGITS-1:0] b;
        m = v;
        n = 1'b0;
`ifdef BCD_SIGN_MAG_EN
        if (v[W_IN-1]) begin
            n = 1'b1;
            m = (1 << W_IN) - int'(v);
        end
`endif
        b = '0;
        for (int d = 0; d < DIGITS; d++) begin
            b[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {n, b};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [4*DIGITS:0] e;
        int                l;
        ncyc++;
        if (done === 1'b1) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result", {7'd0, neg, bcd_out}, {7'd0, e});
                check("latency", ncyc, l);
                last_exp = e[4*DIGITS-1:0];
            end
        end else if (busy === 1'b1) begin
            check("hold", {8'd0, bcd_out}, {8'd0, last_exp});
        end
        prev_done = done;
    end

    task automatic at_negedge();
        @(negedge clk);
        #1;
    endtask

    // caller positions at negedge+1; start is sampled at the following posedge
    task automatic drive_start(input logic [W_IN-1:0] v, input bit accept, output int at_cyc);
        at_cyc = ncyc;
        start  = 1'b1;
        bin_in = v;
        if (accept) begin
            exp_q.push_back(model(v));
            lat_q.push_back(ncyc + LAT);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            at_negedge();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t0, t1, bc;
        logic [W_IN-1:0] rv;
        n_checks  = 0;
        n_errors  = 0;
        ncyc      = 0;
        prev_done = 1'b0;
        last_exp  = '0;
        start     = 1'b0;
        bin_in    = '0;
        rst       = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {8'd0, bcd_out}, 32'd0);
        check("rst_neg", {31'd0, neg}, 32'd0);
        rst = 1'b0;

        // basic conversion with busy window
        at_negedge();
        drive_start(17'd437, 1'b1, t0);
        wait_done(bc);
        check("busy_cycles", bc, W_IN);

        // range ends
        at_negedge();
        drive_start(17'd0, 1'b1, t0);
        wait_done(bc);
        at_negedge();
        drive_start(17'd131071, 1'b1, t0);
        wait_done(bc);

        // starts while busy and in the done cycle are dropped
        at_negedge();
        drive_start(17'd99999, 1'b1, t0);
        repeat (4) at_negedge();
        drive_start(17'd12345, 1'b0, t1);
        wait_done(bc);
        drive_start(17'd12345, 1'b0, t1);
        repeat (25) at_negedge();
        check("ignored_starts", exp_q.size(), 32'd0);

        // reset mid-conversion aborts without done
        at_negedge();
        drive_start(17'd4321, 1'b0, t0);
        repeat (7) at_negedge();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcd", {8'd0, bcd_out}, 32'd0);
        check("abort_neg", {31'd0, neg}, 32'd0);
        rst      = 1'b0;
        last_exp = '0;
        repeat (20) at_negedge();

        // rst beats a simultaneous start
        start  = 1'b1;
        bin_in = 17'd777;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_wins_busy", {31'd0, busy}, 32'd0);
        at_negedge();
        check("rst_wins_idle", {31'd0, busy}, 32'd0);

        at_negedge();
        drive_start(17'd4321, 1'b1, t0);
        wait_done(bc);

        // back-to-back, including sign-mode corner values
        at_negedge();
        drive_start(17'h1FFFF, 1'b1, t0);
        wait_done(bc);
        at_negedge();
        drive_start(17'h10000, 1'b1, t1);
        check("spacing", t1 - t0, W_IN + 2);
        wait_done(bc);
        at_negedge();
        drive_start(17'd437, 1'b1, t0);
        check("spacing", t0 - t1, W_IN + 2);
        wait_done(bc);

        for (int k = 0; k < 6; k++) begin
            rv = 17'($urandom_range(0, 131071));
            at_negedge();
            drive_start(rv, 1'b1, t0);
            wait_done(bc);
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) at_negedge();
        check("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
